// File: rtl/hid_event_queue.sv
// Multi-channel HID event FIFO: one inferred-RAM queue per channel behind a
// 64-bit register window (DATA / STATUS / CTRL per channel, 32-byte stride).

module hid_evq_chan #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter bit EDGE   = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     ev_valid_i,
    input  logic [DATA_W-1:0]        ev_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic                     clr_ovf_i,
    input  logic                     irqen_we_i,
    input  logic                     irqen_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [15:0]              ovf_o,
    output logic                     irq_en_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]     level_q, level_d;
    logic [15:0]       ovf_q, ovf_d;
    logic              valid_q, irq_en_q, irq_en_d;
    logic              push, do_push, do_pop, ovf_inc;

    assign empty_o  = (level_q == '0);
    assign full_o   = (level_q == LW'(DEPTH));
    assign head_o   = mem[head_q];
    assign level_o  = level_q;
    assign ovf_o    = ovf_q;
    assign irq_en_o = irq_en_q;

    always_comb begin
        push     = EDGE ? (ev_valid_i & ~valid_q) : ev_valid_i;
        do_pop   = pop_i & ~empty_o;
        // A pop in the same cycle frees the slot, so a push at full still lands.
        do_push  = push & ~flush_i & (~full_o | do_pop);
        ovf_inc  = push & ~flush_i & full_o & ~do_pop;
        head_d   = head_q;
        tail_d   = tail_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        irq_en_d = irqen_we_i ? irqen_i : irq_en_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (do_pop)  head_d = head_q + 1'b1;
            if (do_push) tail_d = tail_q + 1'b1;
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
        if (clr_ovf_i)                      ovf_d = '0;
        else if (ovf_inc && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            valid_q  <= ev_valid_i;
            irq_en_q <= irq_en_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[tail_q] <= ev_data_i;
    end
endmodule

module hid_event_queue #(
    parameter int               NCHAN     = 2,
    parameter int               DATA_W    = 32,
    parameter int               DEPTH     = 16,
    parameter logic [NCHAN-1:0] EDGE_MASK = NCHAN'(2'b01)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NCHAN-1:0]        ev_valid_i,
    input  logic [NCHAN*DATA_W-1:0] ev_data_i,
    input  logic                    hid_en,
    input  logic [7:0]              hid_we,
    input  logic [19:0]             hid_addr,
    input  logic [63:0]             hid_wrdata,
    output logic [63:0]             hid_rddata,
    output logic                    irq_o
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] NCH = (CW+1)'(NCHAN);

    logic [NCHAN-1:0][DATA_W-1:0] head;
    logic [NCHAN-1:0][LW-1:0]     level;
    logic [NCHAN-1:0][15:0]       ovf;
    logic [NCHAN-1:0]             empty, full, irq_en, pop, ctrl_wr;
    logic [CW-1:0]                sel;
    logic [1:0]                   rsel;
    logic                         bus_rd, bus_wr, sel_ok;
    logic [63:0]                  rddata_q, rddata_d;
    logic                         irq_q, irq_d;
    logic                         unused_bits;

    assign sel    = hid_addr[5 +: CW];
    assign rsel   = hid_addr[4:3];
    assign sel_ok = ({1'b0, sel} < NCH);
    assign bus_wr = hid_en & (|hid_we);
    assign bus_rd = hid_en & ~(|hid_we);
    assign unused_bits = ^{hid_addr[2:0], hid_addr[19:5+CW], hid_wrdata[63:3]};

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        assign pop[i]     = bus_wr & sel_ok & (sel == CW'(i)) & (rsel == 2'd0);
        assign ctrl_wr[i] = bus_wr & sel_ok & (sel == CW'(i)) & (rsel == 2'd2);

        hid_evq_chan #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .EDGE   (EDGE_MASK[i])
        ) u_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .ev_valid_i (ev_valid_i[i]),
            .ev_data_i  (ev_data_i[i*DATA_W +: DATA_W]),
            .pop_i      (pop[i]),
            .flush_i    (ctrl_wr[i] & hid_wrdata[0]),
            .clr_ovf_i  (ctrl_wr[i] & hid_wrdata[2]),
            .irqen_we_i (ctrl_wr[i]),
            .irqen_i    (hid_wrdata[1]),
            .head_o     (head[i]),
            .empty_o    (empty[i]),
            .full_o     (full[i]),
            .level_o    (level[i]),
            .ovf_o      (ovf[i]),
            .irq_en_o   (irq_en[i])
        );
    end

    always_comb begin
        rddata_d = '0;
        if (bus_rd && sel_ok) begin
            for (int i = 0; i < NCHAN; i++) begin
                if (sel == CW'(i)) begin
                    case (rsel)
                        2'd0: begin
                            // RAM is uninitialised after reset, so mask the payload while empty.
                            rddata_d[63] = empty[i];
                            rddata_d[DATA_W-1:0] = empty[i] ? '0 : head[i];
                        end
                        2'd1: begin
                            rddata_d[0]     = empty[i];
                            rddata_d[1]     = full[i];
                            rddata_d[16:8]  = 9'(level[i]);
                            rddata_d[47:32] = ovf[i];
                        end
                        2'd2:    rddata_d[1] = irq_en[i];
                        default: rddata_d = '0;
                    endcase
                end
            end
        end
        irq_d = |(irq_en & ~empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rddata_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            rddata_q <= rddata_d;
            irq_q    <= irq_d;
        end
    end

    assign hid_rddata = rddata_q;
    assign irq_o      = irq_q;
endmodule

// File: tb/tb_hid_event_queue.sv
// Bench for hid_event_queue: register-access vector table, directed corner
// sequences, then random traffic against a queue-based reference model.

module tb_hid_event_queue;
    localparam int DEPTH = 16;
    localparam logic [1:0] EDGE = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ev_valid = '0;
    logic [63:0] ev_data = '0;
    logic        hid_en = 1'b0;
    logic [7:0]  hid_we = '0;
    logic [19:0] hid_addr = '0;
    logic [63:0] hid_wrdata = '0;
    logic [63:0] hid_rddata;
    logic        irq;

    int tests = 0;
    int fails = 0;

    hid_event_queue #(
        .NCHAN(2), .DATA_W(32), .DEPTH(DEPTH), .EDGE_MASK(EDGE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .ev_valid_i(ev_valid), .ev_data_i(ev_data),
        .hid_en(hid_en), .hid_we(hid_we), .hid_addr(hid_addr),
        .hid_wrdata(hid_wrdata), .hid_rddata(hid_rddata), .irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        int          ch;
        int          rg;
        logic [63:0] wd;
        logic [63:0] exp;
        string       name;
    } vec_t;

    // reference model state
    logic [31:0] mq [2][$];
    int          movf [2];
    bit          mien [2];
    bit          mprev [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic set_bus(input bit en, input bit wr, input int ch, input int rg, input logic [63:0] wd);
        hid_en     = en;
        hid_we     = wr ? 8'hFF : 8'h00;
        hid_addr   = 20'(ch * 32 + rg * 8);
        hid_wrdata = wd;
    endtask

    task automatic bus_rd(input int ch, input int rg, output logic [63:0] d);
        set_bus(1'b1, 1'b0, ch, rg, '0);
        tick();
        d = hid_rddata;
        set_bus(1'b0, 1'b0, 0, 0, '0);
    endtask

    task automatic bus_wr(input int ch, input int rg, input logic [63:0] wd);
        set_bus(1'b1, 1'b1, ch, rg, wd);
        tick();
        set_bus(1'b0, 1'b0, 0, 0, '0);
    endtask

    task automatic rd_chk(input string nm, input int ch, input int rg, input logic [63:0] exp);
        logic [63:0] d;
        bus_rd(ch, rg, d);
        check(nm, d, exp);
    endtask

    task automatic drive_ev(input int ch, input bit v, input logic [31:0] d);
        ev_valid[ch] = v;
        ev_data[ch*32 +: 32] = d;
    endtask

    function automatic logic [63:0] mexp(input int ch, input int rg);
        int sz = mq[ch].size();
        case (rg)
            0: return (sz == 0) ? 64'h8000_0000_0000_0000 : {32'h0, mq[ch][0]};
            1: return (64'(movf[ch]) << 32) | (64'(sz) << 8) |
                      ((sz == DEPTH) ? 64'd2 : 64'd0) | ((sz == 0) ? 64'd1 : 64'd0);
            2: return 64'(mien[ch]) << 1;
            default: return 64'h0;
        endcase
    endfunction

    vec_t vt [13];

    initial begin
        logic [63:0] d;

        vt[0]  = '{0, 0, 1, 64'h0, 64'h1,                   "rst_status0"};
        vt[1]  = '{0, 0, 0, 64'h0, 64'h8000_0000_0000_0000, "rst_data0"};
        vt[2]  = '{0, 1, 1, 64'h0, 64'h1,                   "rst_status1"};
        vt[3]  = '{0, 0, 2, 64'h0, 64'h0,                   "rst_ctrl0"};
        vt[4]  = '{0, 0, 3, 64'h0, 64'h0,                   "rsvd_rd"};
        vt[5]  = '{1, 0, 2, 64'h2, 64'h0,                   "wr_irqen"};
        vt[6]  = '{0, 0, 2, 64'h0, 64'h2,                   "ctrl_irqen"};
        vt[7]  = '{1, 0, 3, 64'hFFFF, 64'h0,                "wr_rsvd"};
        vt[8]  = '{0, 0, 3, 64'h0, 64'h0,                   "rsvd_after_wr"};
        vt[9]  = '{1, 0, 0, 64'h0, 64'h0,                   "pop_empty"};
        vt[10] = '{0, 0, 1, 64'h0, 64'h1,                   "status_pop_empty"};
        vt[11] = '{1, 0, 2, 64'h0, 64'h0,                   "wr_ctrl0"};
        vt[12] = '{0, 0, 2, 64'h0, 64'h0,                   "ctrl_cleared"};

        repeat (3) tick();
        check("rst_rddata", hid_rddata, 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        rst_n = 1'b1;
        tick();

        foreach (vt[k]) begin
            if (vt[k].wr) bus_wr(vt[k].ch, vt[k].rg, vt[k].wd);
            else begin
                bus_rd(vt[k].ch, vt[k].rg, d);
                check(vt[k].name, d, vt[k].exp);
            end
        end
        check("irq_idle", 64'(irq), 64'h0);
        bus_rd(0, 0, d);
        tick();
        check("rd_idle_zero", hid_rddata, 64'h0);

        // level-mode channel: one push per high cycle
        drive_ev(1, 1, 32'hA1); tick();
        drive_ev(1, 1, 32'hA2); tick();
        drive_ev(1, 1, 32'hA3); tick();
        drive_ev(1, 0, 32'h0);
        rd_chk("lvl_status", 1, 1, 64'h300);
        for (int k = 0; k < 3; k++) begin
            rd_chk("lvl_data", 1, 0, 64'(32'hA1 + k));
            bus_wr(1, 0, 64'h0);
        end
        rd_chk("lvl_empty", 1, 1, 64'h1);

        // edge-mode channel: held level yields a single push
        drive_ev(0, 1, 32'h5A);
        repeat (5) tick();
        drive_ev(0, 0, 32'h5A);
        rd_chk("edge_one", 0, 1, 64'h100);
        tick();
        drive_ev(0, 1, 32'h5A); tick();
        drive_ev(0, 0, 32'h0);
        rd_chk("edge_two", 0, 1, 64'h200);
        bus_wr(0, 2, 64'h1);
        rd_chk("flush0", 0, 1, 64'h1);

        // overflow, full push+pop, clear overflow
        for (int k = 0; k < 19; k++) begin
            drive_ev(1, 1, 32'h100 + 32'(k));
            tick();
        end
        drive_ev(1, 0, 32'h0);
        rd_chk("full_status", 1, 1, 64'h0000_0003_0000_1002);
        rd_chk("full_head", 1, 0, 64'h100);
        drive_ev(1, 1, 32'h300);
        bus_wr(1, 0, 64'h0);
        drive_ev(1, 0, 32'h0);
        rd_chk("full_pushpop", 1, 1, 64'h0000_0003_0000_1002);
        rd_chk("full_head2", 1, 0, 64'h101);
        bus_wr(1, 2, 64'h4);
        rd_chk("ovf_clear", 1, 1, 64'h1002);
        bus_wr(1, 2, 64'h1);
        rd_chk("flush1", 1, 1, 64'h1);

        // interrupt timing and flush racing a push
        bus_wr(0, 2, 64'h2);
        drive_ev(0, 1, 32'h77); tick();
        check("irq_lat1", 64'(irq), 64'h0);
        tick();
        check("irq_lat2", 64'(irq), 64'h1);
        drive_ev(0, 0, 32'h0); tick();
        drive_ev(0, 1, 32'h78);
        bus_wr(0, 2, 64'h3);
        drive_ev(0, 0, 32'h0);
        check("irq_hold", 64'(irq), 64'h1);
        tick();
        check("irq_fall", 64'(irq), 64'h0);
        rd_chk("flush_vs_push", 0, 1, 64'h1);
        bus_wr(0, 2, 64'h0);

        // async reset mid-stream
        bus_wr(1, 2, 64'h2);
        drive_ev(1, 1, 32'hC0);
        repeat (7) tick();
        drive_ev(1, 0, 32'h0);
        rd_chk("pre_rst_status", 1, 1, 64'h700);
        check("pre_rst_irq", 64'(irq), 64'h1);
        rst_n = 1'b0;
        #2;
        check("rst_async_rd", hid_rddata, 64'h0);
        check("rst_async_irq", 64'(irq), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        rd_chk("post_rst_st0", 0, 1, 64'h1);
        rd_chk("post_rst_st1", 1, 1, 64'h1);
        rd_chk("post_rst_ctrl1", 1, 2, 64'h0);

        // random traffic against the reference model
        for (int c = 0; c < 2; c++) begin
            mq[c].delete();
            movf[c] = 0;
            mien[c] = 0;
            mprev[c] = 0;
        end
        for (int n = 0; n < 600; n++) begin
            logic [1:0]  v;
            logic [31:0] dat [2];
            int          op, ch, rg;
            bit          wr, rd;
            logic [63:0] wd, exp_rd;
            bit          exp_irq;

            v = 2'($urandom_range(0, 3));
            dat[0] = $urandom;
            dat[1] = $urandom;
            op = $urandom_range(0, 9);
            ch = $urandom_range(0, 1);
            rg = $urandom_range(0, 3);
            wd = '0;
            rd = (op <= 3);
            wr = (op >= 4 && op <= 7);
            if (op == 4 || op == 5) rg = 0;
            if (op == 6) begin
                rg = 2;
                wd = {61'h0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 5) == 0)};
            end
            if (op == 7) rg = 3;

            exp_rd = rd ? mexp(ch, rg) : 64'h0;
            exp_irq = (mien[0] && mq[0].size() > 0) || (mien[1] && mq[1].size() > 0);
            for (int c = 0; c < 2; c++) begin
                bit push, pop, ctl;
                push = EDGE[c] ? (v[c] && !mprev[c]) : v[c];
                pop  = wr && rg == 0 && ch == c;
                ctl  = wr && rg == 2 && ch == c;
                if (ctl && wd[0]) mq[c].delete();
                else begin
                    if (pop && mq[c].size() > 0) void'(mq[c].pop_front());
                    if (push) begin
                        if (mq[c].size() < DEPTH) mq[c].push_back(dat[c]);
                        else if (movf[c] < 65535) movf[c]++;
                    end
                end
                if (ctl && wd[2]) movf[c] = 0;
                if (ctl) mien[c] = wd[1];
                mprev[c] = v[c];
            end

            ev_valid = v;
            ev_data  = {dat[1], dat[0]};
            set_bus(rd || wr, wr, ch, rg, wd);
            tick();
            check("rand_rd", hid_rddata, exp_rd);
            check("rand_irq", 64'(irq), 64'(exp_irq));
        end
        ev_valid = '0;
        set_bus(1'b0, 1'b0, 0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hid_event_queue.md
Name: hid_event_queue

Overview:
- Parametrised multi-channel event FIFO for the HID subsystem. It generalises the fixed keyboard (9-bit) and mouse (32-bit) queues into NCHAN inferred-RAM queues of configurable width and depth, with no vendor FIFO primitives.
- Sits between the PS/2 decoders (keyboard, mouse, and future sources) and the hid_* memory-mapped bus.
- Adds per-channel edge/level capture mode, software flush, saturating overflow counter, fill level and interrupt output.

Parameters:
- NCHAN, 2, number of event channels (1..8).
- DATA_W, 32, event payload width per channel (1..62).
- DEPTH, 16, entries per channel; power of two, 2..256.
- EDGE_MASK, 2'b01, per-channel capture mode. Bit i = 1 pushes only on a rising edge of ev_valid_i[i]; 0 pushes on every cycle ev_valid_i[i] is high.

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rst_ni  in  1  asynchronous active-low reset.
- ev_valid_i  in  NCHAN  per-channel event strobe/level from the decoders.
- ev_data_i  in  NCHAN*DATA_W  payloads; channel i occupies [i*DATA_W +: DATA_W].
- hid_en  in  1  bus access enable.
- hid_we  in  8  byte write enables; any bit set = write access.
- hid_addr  in  20  byte address. Bits [4:3] select the register, [5 +: CW] select the channel (CW = max(1, clog2(NCHAN))); other bits are ignored.
- hid_wrdata  in  64  write data.
- hid_rddata  out  64  read data, registered, valid one cycle after the access.
- irq_o  out  1  level interrupt, registered.

Behaviour:
- Register map per channel (32-byte stride):
  - 0x00 DATA. Read: {empty, 63-DATA_W zeros, head entry}. Any write pops one entry.
  - 0x08 STATUS. Read only. Bit0 empty, bit1 full, [16:8] level (0..DEPTH), [47:32] overflow count, other bits 0.
  - 0x10 CTRL. Write: bit0 flush (self-clearing), bit1 irq_en (stored), bit2 clear overflow count (self-clearing). Read: {62'b0, irq_en, 1'b0}.
  - 0x18 reserved: reads 0, writes ignored.
- A channel index >= NCHAN reads 0, and writes to it are ignored.
- Reads: when hid_en=1 and hid_we=0, hid_rddata is updated at the next posedge. When hid_en=0 it holds 0 the following cycle.
- Reads are non-destructive. A DATA read returns the head entry as it was in the access cycle.
- Push condition for channel i:
  - EDGE_MASK[i] = 1: ev_valid_i[i] & ~valid_q[i], where valid_q is a 1-cycle register of ev_valid_i.
  - EDGE_MASK[i] = 0: ev_valid_i[i].
  - Data is written into the tail slot on the same posedge.
- Pop: a write to DATA advances the head at that posedge. Pop when empty is ignored; the pointers, level and flags are unchanged.
- Full:
  - A push while full and with no simultaneous pop is dropped. The overflow count is incremented and saturates at 16'hFFFF.
  - Push and pop together while full: both happen, level stays DEPTH, no overflow.
- Empty: push and pop in the same cycle while empty performs the push only (level becomes 1).
- Flush: head, tail and level go to 0 at the posedge. It overrides any push in the same cycle (that event is lost and not counted). The overflow count is retained.
- Clear overflow in the same cycle as an overflow: the count becomes 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level is log2(DEPTH)+1 bits. full = (level == DEPTH), empty = (level == 0).
- irq_o is registered: irq_o <= OR over channels of (irq_en[i] & ~empty[i]). It asserts one cycle after a push into an enabled empty channel.
- Reset (async assert, sync release):
  - All pointers, levels, overflow counts, irq_en and valid_q = 0.
  - hid_rddata = 0, irq_o = 0.
  - RAM contents are undefined, but DATA reads return 0 in the payload field while empty.

Test Plan:
- Reset, then read STATUS ch0 -> 64'h0000_0000_0000_0001. Read DATA ch0 -> 64'h8000_0000_0000_0000.
- ch1 (level mode): ev_valid=1 for 3 cycles with data 0xA1, 0xA2, 0xA3 -> STATUS level=3. Three DATA read+pop pairs return 0xA1, 0xA2, 0xA3 in order, then empty=1.
- ch0 (edge mode): ev_valid held high 5 cycles with data 0x5A -> exactly one entry (level=1). Low 1 cycle, then high again -> level=2.
- Fill ch1 to DEPTH=16, then push 3 more -> full=1, overflow=3, the first entry is still head. Push+pop in the same cycle at full -> level stays 16, overflow stays 3. Write CTRL bit2 -> overflow=0.
- Set irq_en ch0, push one event -> irq_o=1 two cycles after ev_valid rises. Flush ch0 while a push is coincident -> level=0, irq_o falls next cycle.
- Assert rst_ni low mid-stream with 7 entries queued -> hid_rddata, irq_o and all levels 0 immediately. After release, ch0 STATUS = 64'h1.
